alarm_ringer: RTL and testbench



---
 rtl/alarm_ringer_if.sv | 27 ++
 rtl/alarm_ringer.sv | 163 ++++++++++++++++
 tb/tb_alarm_ringer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/alarm_ringer_if.sv
// alarm_ringer_if: bundles the alarm ringer's mode/alarm/key inputs and buzzer/status outputs.
// Rev 1.0
`default_nettype none

interface alarm_ringer_if;
  logic [2:0] sys_status;
  logic       reach_alarm_time;
  logic       sec_tick;
  logic [3:0] neg_keys_filtered;
  logic       buzzer;
  logic       ringing;
  logic       snoozing;
  logic [2:0] snooze_left;
  logic       missed;

  modport master (
    output sys_status, reach_alarm_time, sec_tick, neg_keys_filtered,
    input  buzzer, ringing, snoozing, snooze_left, missed
  );

  modport slave (
    input  sys_status, reach_alarm_time, sec_tick, neg_keys_filtered,
    output buzzer, ringing, snoozing, snooze_left, missed
  );
endinterface

`default_nettype wire

// File: rtl/alarm_ringer.sv
// alarm_ringer: ring/snooze/dismiss FSM with tone generator; ALARM_BEEP_PATTERN_EN adds 1 s on/off beeping.
// Rev 1.0
`default_nettype none

module alarm_ringer #(
  parameter logic [15:0] TONE_DIV      = 16'd25000,
  parameter logic [15:0] RING_SECS     = 16'd60,
  parameter logic [15:0] SNOOZE_SECS   = 16'd300,
  parameter logic [2:0]  MAX_SNOOZE    = 3'd3,
  parameter logic [2:0]  S_ALARMTUNING = 3'd5,
  parameter logic [3:0]  K_SNOOZE      = 4'b0100,
  parameter logic [3:0]  K_DISMISS     = 4'b1000
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  alarm_ringer_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_reach_d;
  logic        r_ringing;
  logic        r_snoozing;
  logic        r_missed;
  logic [2:0]  r_snooze_left;
  logic [15:0] r_ring_cnt;
  logic [15:0] r_snz_cnt;
  logic [15:0] r_tone_cnt;
  logic        r_tone;

  logic w_trig;
  logic w_tuning;
  logic w_dismiss;
  logic w_snooze_key;
  logic w_key_any;

  assign w_trig       = bus.reach_alarm_time & ~r_reach_d;
  assign w_tuning     = (bus.sys_status == S_ALARMTUNING);
  assign w_dismiss    = (bus.neg_keys_filtered == K_DISMISS);
  assign w_snooze_key = (bus.neg_keys_filtered == K_SNOOZE);
  assign w_key_any    = (bus.neg_keys_filtered != 4'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_reach_d     <= 1'b0;
      r_ringing     <= 1'b0;
      r_snoozing    <= 1'b0;
      r_missed      <= 1'b0;
      r_snooze_left <= MAX_SNOOZE;
      r_ring_cnt    <= 16'd0;
      r_snz_cnt     <= 16'd0;
    end else begin
      r_reach_d <= bus.reach_alarm_time;
      // Clear first so a timeout set later in this block takes precedence.
      if (w_key_any || (w_trig && !w_tuning))
        r_missed <= 1'b0;

      if (w_tuning) begin
        r_state    <= ST_IDLE;
        r_ringing  <= 1'b0;
        r_snoozing <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_trig) begin
              r_state       <= ST_RINGING;
              r_ringing     <= 1'b1;
              r_ring_cnt    <= RING_SECS;
              r_snooze_left <= MAX_SNOOZE;
            end
          end
          ST_RINGING: begin
            if (w_dismiss) begin
              r_state   <= ST_IDLE;
              r_ringing <= 1'b0;
            end else if (w_snooze_key && (r_snooze_left != 3'd0)) begin
              r_state       <= ST_SNOOZE;
              r_ringing     <= 1'b0;
              r_snoozing    <= 1'b1;
              r_snooze_left <= r_snooze_left - 3'd1;
              r_snz_cnt     <= SNOOZE_SECS;
            end else if (bus.sec_tick) begin
              if (r_ring_cnt == 16'd1) begin
                r_state   <= ST_IDLE;
                r_ringing <= 1'b0;
                r_missed  <= 1'b1;
              end else begin
                r_ring_cnt <= r_ring_cnt - 16'd1;
              end
            end
          end
          ST_SNOOZE: begin
            if (w_dismiss) begin
              r_state    <= ST_IDLE;
              r_snoozing <= 1'b0;
            end else if (bus.sec_tick) begin
              if (r_snz_cnt == 16'd1) begin
                r_state    <= ST_RINGING;
                r_snoozing <= 1'b0;
                r_ringing  <= 1'b1;
                r_ring_cnt <= RING_SECS;
              end else begin
                r_snz_cnt <= r_snz_cnt - 16'd1;
              end
            end
          end
          default: begin
            r_state    <= ST_IDLE;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
          end
        endcase
      end
    end
  end

  // Tone only advances while ringing, so every ring starts from a silent half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tone_cnt <= 16'd0;
      r_tone     <= 1'b0;
    end else if (r_state != ST_RINGING) begin
      r_tone_cnt <= 16'd0;
      r_tone     <= 1'b0;
    end else if (r_tone_cnt == (TONE_DIV - 16'd1)) begin
      r_tone_cnt <= 16'd0;
      r_tone     <= ~r_tone;
    end else begin
      r_tone_cnt <= r_tone_cnt + 16'd1;
    end
  end

`ifdef ALARM_BEEP_PATTERN_EN
  logic r_beep_phase;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_beep_phase <= 1'b0;
    else if (r_state != ST_RINGING)
      r_beep_phase <= 1'b0;
    else if (bus.sec_tick)
      r_beep_phase <= ~r_beep_phase;
  end

  assign bus.buzzer = r_tone & r_ringing & ~r_beep_phase;
`else
  assign bus.buzzer = r_tone & r_ringing;
`endif

  assign bus.ringing     = r_ringing;
  assign bus.snoozing    = r_snoozing;
  assign bus.snooze_left = r_snooze_left;
  assign bus.missed      = r_missed;

endmodule

`default_nettype wire

// File: tb/tb_alarm_ringer.sv
// tb_alarm_ringer: directed checks of ringing, snooze, timeout, dismiss, tuning override and reset.
// Rev 1.0
`default_nettype none

module tb_alarm_ringer;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alarm_ringer_if bus ();

  alarm_ringer #(
    .TONE_DIV      (16'd4),
    .RING_SECS     (16'd5),
    .SNOOZE_SECS   (16'd3),
    .MAX_SNOOZE    (3'd2),
    .S_ALARMTUNING (3'd5),
    .K_SNOOZE      (4'b0100),
    .K_DISMISS     (4'b1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_key(input logic [3:0] k);
    bus.neg_keys_filtered = k;
    cyc();
    bus.neg_keys_filtered = 4'd0;
  endtask

  task automatic tick();
    bus.sec_tick = 1'b1;
    cyc();
    bus.sec_tick = 1'b0;
  endtask

  task automatic trig_pulse();
    bus.reach_alarm_time = 1'b1;
    cyc();
    bus.reach_alarm_time = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic bz, input logic rg,
                            input logic sz, input logic [2:0] sl, input logic ms);
    check({tag, ".buzzer"},      {31'd0, bus.buzzer},      {31'd0, bz});
    check({tag, ".ringing"},     {31'd0, bus.ringing},     {31'd0, rg});
    check({tag, ".snoozing"},    {31'd0, bus.snoozing},    {31'd0, sz});
    check({tag, ".snooze_left"}, {29'd0, bus.snooze_left}, {29'd0, sl});
    check({tag, ".missed"},      {31'd0, bus.missed},      {31'd0, ms});
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.sys_status        = 3'd0;
    bus.reach_alarm_time  = 1'b0;
    bus.sec_tick          = 1'b0;
    bus.neg_keys_filtered = 4'd0;
    repeat (3) cyc();
    check_outs("reset", 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
    rst_n = 1'b1;
    cyc();
    check_outs("idle", 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);

    // Held alarm level: one event, tone half-period of 4 cycles
    bus.reach_alarm_time = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      cyc();
      check("hold.ringing", {31'd0, bus.ringing}, 32'd1);
      check("hold.buzzer", {31'd0, bus.buzzer}, ((n - 1) / 4) % 2);
    end
    check("hold.snooze_left", {29'd0, bus.snooze_left}, 32'd2);
    bus.reach_alarm_time = 1'b0;

    // Snooze, re-ring after 3 s, snooze again, then exhausted snooze ignored
    pulse_key(4'b0100);
    check_outs("snz1", 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    tick();
    tick();
    check("snz1.still", {31'd0, bus.snoozing}, 32'd1);
    tick();
    check_outs("rering1", 1'b0, 1'b1, 1'b0, 3'd1, 1'b0);
    pulse_key(4'b0100);
    check_outs("snz2", 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    repeat (3) tick();
    check_outs("rering2", 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    pulse_key(4'b0100);
    check("snz3.ignored.ringing", {31'd0, bus.ringing}, 32'd1);
    check("snz3.ignored.snoozing", {31'd0, bus.snoozing}, 32'd0);

    // Ring timeout after 5 ticks sets missed; any key clears it
    repeat (4) tick();
    check("timeout.tick4", {31'd0, bus.ringing}, 32'd1);
    tick();
    check_outs("timeout", 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    pulse_key(4'b0001);
    check("missed.clear", {31'd0, bus.missed}, 32'd0);

    // Key and tick together: snooze wins, snooze count starts full
    trig_pulse();
    check_outs("trig2", 1'b0, 1'b1, 1'b0, 3'd2, 1'b0);
    bus.neg_keys_filtered = 4'b0100;
    bus.sec_tick = 1'b1;
    cyc();
    bus.neg_keys_filtered = 4'd0;
    bus.sec_tick = 1'b0;
    check_outs("same_cycle", 1'b0, 1'b0, 1'b1, 3'd1, 1'b0);
    tick();
    tick();
    check("same_cycle.two", {31'd0, bus.snoozing}, 32'd1);
    tick();
    check("same_cycle.three", {31'd0, bus.ringing}, 32'd1);

    // Dismiss from RINGING and from SNOOZE
    pulse_key(4'b1000);
    check_outs("dismiss.ring", 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);
    trig_pulse();
    pulse_key(4'b0100);
    check("dismiss.pre_snz", {31'd0, bus.snoozing}, 32'd1);
    pulse_key(4'b1000);
    check_outs("dismiss.snz", 1'b0, 1'b0, 1'b0, 3'd1, 1'b0);

    // Tuning override and trigger suppression
    trig_pulse();
    check("tune.pre", {31'd0, bus.ringing}, 32'd1);
    bus.sys_status = 3'd5;
    cyc();
    check("tune.force_idle", {31'd0, bus.ringing}, 32'd0);
    trig_pulse();
    check("tune.no_ring", {31'd0, bus.ringing}, 32'd0);
    bus.sys_status = 3'd0;
    cyc();
    check("tune.after", {31'd0, bus.ringing}, 32'd0);

    // Timeout with a stray key in the same cycle: set wins; trig clears missed
    trig_pulse();
    repeat (4) tick();
    bus.neg_keys_filtered = 4'b0001;
    bus.sec_tick = 1'b1;
    cyc();
    bus.neg_keys_filtered = 4'd0;
    bus.sec_tick = 1'b0;
    check_outs("set_wins", 1'b0, 1'b0, 1'b0, 3'd2, 1'b1);
    trig_pulse();
    check("trig_clears.missed", {31'd0, bus.missed}, 32'd0);
    check("trig_clears.ringing", {31'd0, bus.ringing}, 32'd1);

    // Asynchronous reset mid-snooze
    pulse_key(4'b0100);
    check("rst.pre", {31'd0, bus.snoozing}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 1'b0, 3'd2, 1'b0);
    cyc();
    rst_n = 1'b1;
    cyc();

`ifdef ALARM_BEEP_PATTERN_EN
    trig_pulse();
    for (int n = 2; n <= 30; n++) begin
      bus.sec_tick = (n == 10) || (n == 20);
      cyc();
      check("beep.buzzer", {31'd0, bus.buzzer},
            ((n >= 10) && (n < 20)) ? 32'd0 : ((n - 1) / 4) % 2);
    end
    bus.sec_tick = 1'b0;
    pulse_key(4'b1000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
